// File: rtl/soc_system_hps_dsp_status_in.sv
// soc_system_hps_dsp_status_in: Avalon-MM status input port with sync, debounce, edge capture and irq
// Ports: clk/reset_n (async active-low); address/chipselect/write_n/writedata slave write side;
//        readdata zero-wait combinational read of DATA, DEBOUNCE, IRQMASK or EDGECAP;
//        in_port asynchronous status lines; irq = |(edgecap & irqmask).
module soc_system_hps_dsp_status_in #(
    parameter int WIDTH          = 8,
    parameter int DEBOUNCE_W     = 16,
    parameter int DEBOUNCE_RESET = 1000,
    parameter int EDGE_TYPE      = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] s1, s2, db, irqmask, edgecap, upd, ev, clr;
    logic [DEBOUNCE_W-1:0] lim;
    logic [DEBOUNCE_W-1:0] cnt [WIDTH];
    logic wr, unused;
    assign wr = chipselect && !write_n;
    assign unused = ^writedata;
    assign clr = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    // upd marks the clock on which a bit's debounced value flips; db still holds the old value here
    assign ev = EDGE_TYPE == 0 ? upd & ~db : EDGE_TYPE == 1 ? upd & db : upd;
    assign irq = |(edgecap & irqmask);
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            assign upd[i] = s2[i] != db[i] && cnt[i] >= lim;
            always_ff @(posedge clk or negedge reset_n)
                if (!reset_n) cnt[i] <= '0;
                else cnt[i] <= (s2[i] == db[i] || upd[i]) ? '0 : cnt[i] + DEBOUNCE_W'(1);
        end
    endgenerate
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            s1      <= '0;
            s2      <= '0;
            db      <= '0;
            irqmask <= '0;
            edgecap <= '0;
            lim     <= DEBOUNCE_W'(DEBOUNCE_RESET);
        end else begin
            s1      <= in_port;
            s2      <= s1;
            db      <= db ^ upd;
            edgecap <= (edgecap & ~clr) | ev;
            if (wr && address == 2'd1) lim <= writedata[DEBOUNCE_W-1:0];
            if (wr && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
        end
    always_comb
        readdata = address == 2'd0 ? 32'(db) :
                   address == 2'd1 ? 32'(lim) :
                   address == 2'd2 ? 32'(irqmask) : 32'(edgecap);
endmodule

// File: tb/tb_soc_system_hps_dsp_status_in.sv
// tb_soc_system_hps_dsp_status_in: directed and random checks against a behavioural model
module tb_soc_system_hps_dsp_status_in;
    logic        clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
    logic [1:0]  address = 0;
    logic [31:0] writedata = 0, readdata, rd;
    logic [7:0]  in_port = 0;
    logic        irq;
    int n_cmp = 0, n_bad = 0;

    soc_system_hps_dsp_status_in dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // Model: per line, a pipeline of two samples, a debounced value, and the age of the
    // current disagreement; the line flips once the disagreement has persisted past the limit.
    logic [7:0] m_s1, m_s2, m_db, m_mask, m_cap, t_db, t_clr;
    int m_L;
    int m_age [8];
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1 <= 0; m_s2 <= 0; m_db <= 0; m_mask <= 0; m_cap <= 0; m_L <= 1000;
            for (int k = 0; k < 8; k++) m_age[k] <= 0;
        end else begin
            t_db = m_db;
            for (int k = 0; k < 8; k++) begin
                if (m_s2[k] == m_db[k]) m_age[k] <= 0;
                else if (m_age[k] >= m_L) begin
                    t_db[k] = m_s2[k];
                    m_age[k] <= 0;
                end else m_age[k] <= m_age[k] + 1;
            end
            t_clr = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
            m_cap <= (m_cap & ~t_clr) | (t_db & ~m_db);
            if (chipselect && !write_n && address == 2'd1) m_L <= int'(writedata[15:0]);
            if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[7:0];
            m_db <= t_db;
            m_s2 <= m_s1;
            m_s1 <= in_port;
        end
    end

    logic [31:0] exp_rd;
    always @(negedge clk) begin
        exp_rd = address == 2'd0 ? {24'd0, m_db} : address == 2'd1 ? m_L :
                 address == 2'd2 ? {24'd0, m_mask} : {24'd0, m_cap};
        n_cmp++;
        if (readdata !== exp_rd) begin
            n_bad++;
            $display("FAIL model_readdata a=%0d got %h expected %h at %0t", address, readdata, exp_rd, $time);
        end
        n_cmp++;
        if (irq !== |(m_cap & m_mask)) begin
            n_bad++;
            $display("FAIL model_irq got %b expected %b at %0t", irq, |(m_cap & m_mask), $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1; write_n = 0; address = a; writedata = d;
        tick();
        chipselect = 0; write_n = 1;
    endtask

    task automatic rdreg(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    logic [31:0] exp_reset [4];

    initial begin
        exp_reset[0] = 0; exp_reset[1] = 1000; exp_reset[2] = 0; exp_reset[3] = 0;
        repeat (3) tick();
        reset_n = 1;
        tick();
        for (int a = 0; a < 4; a++) begin
            rdreg(2'(a), rd);
            check($sformatf("reset_reg%0d", a), rd, exp_reset[a]);
        end
        check("reset_irq", {31'd0, irq}, 0);

        wr(2'd1, 4);
        in_port = 8'h01;
        for (int k = 0; k < 4; k++) tick();
        in_port = 8'h00;
        for (int k = 0; k < 10; k++) begin
            rdreg(2'd0, rd);
            check("short_pulse_data", rd, 0);
            tick();
        end
        in_port = 8'h02;
        repeat (6) tick();
        rdreg(2'd0, rd);
        check("db_before_E6", rd, 0);
        tick();
        rdreg(2'd0, rd);
        check("db_at_E6", rd, 32'h02);
        in_port = 8'h00;
        repeat (10) tick();
        wr(2'd3, 32'hff);

        wr(2'd2, 32'h01);
        wr(2'd1, 0);
        in_port = 8'h01;
        repeat (2) tick();
        rdreg(2'd3, rd);
        check("cap_before_E2", rd, 0);
        tick();
        rdreg(2'd3, rd);
        check("cap_after_E2", rd, 32'h01);
        check("irq_after_E2", {31'd0, irq}, 1);
        in_port = 8'h00;
        repeat (5) tick();
        rdreg(2'd3, rd);
        check("cap_after_fall", rd, 32'h01);

        in_port = 8'h01;
        repeat (2) tick();
        wr(2'd3, 32'h01);
        rdreg(2'd3, rd);
        check("set_beats_clear", rd, 32'h01);
        check("irq_set_beats_clear", {31'd0, irq}, 1);
        repeat (2) tick();
        wr(2'd3, 32'h01);
        rdreg(2'd3, rd);
        check("clean_clear", rd, 0);
        check("irq_after_clear", {31'd0, irq}, 0);

        in_port = 8'h00;
        repeat (4) tick();
        in_port = 8'h05;
        repeat (4) tick();
        wr(2'd2, 32'h02);
        rdreg(2'd3, rd);
        check("cap_masked", rd, 32'h05);
        check("irq_masked", {31'd0, irq}, 0);
        wr(2'd2, 32'h04);
        check("irq_mask4", {31'd0, irq}, 1);

        wr(2'd1, 100);
        in_port = 8'h00;
        repeat (52) tick();
        rdreg(2'd0, rd);
        check("db_held_L100", rd, 32'h05);
        wr(2'd1, 10);
        tick();
        rdreg(2'd0, rd);
        check("db_after_shrink", rd, 0);

        wr(2'd1, 100);
        in_port = 8'h05;
        repeat (20) tick();
        reset_n = 0;
        for (int a = 0; a < 4; a++) begin
            rdreg(2'(a), rd);
            check($sformatf("midreset_reg%0d", a), rd, exp_reset[a]);
        end
        check("midreset_irq", {31'd0, irq}, 0);
        tick();
        reset_n = 1;

        for (int c = 0; c < 4000; c++) begin
            if ($urandom % 4 == 0) in_port = in_port ^ (8'($urandom) & 8'($urandom));
            address = 2'($urandom);
            chipselect = 1'($urandom);
            write_n = ($urandom % 3) != 0;
            writedata = address == 2'd1 ? $urandom % 6 : $urandom;
            if ($urandom % 500 == 0) reset_n = 0;
            tick();
            reset_n = 1;
        end
        chipselect = 0; write_n = 1;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
